mem_port_arbiter: RTL and testbench

//   Shares the single-port main memory between instruction fetch (I port) and the MEM-stage load/store (D port).

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (I) and load/store (D).
// Build option MEM_ARB_RR_EN selects round-robin conflict resolution; default is D-priority with an I starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_req,
  input  logic [ADDR_W-1:0]                 i_addr,
  output logic                              i_gnt,
  output logic                              i_rvalid,
  output logic [DATA_W-1:0]                 i_rdata,
  input  logic                              d_req,
  input  logic                              d_we,
  input  logic [ADDR_W-1:0]                 d_addr,
  input  logic [DATA_W-1:0]                 d_wdata,
  output logic                              d_gnt,
  output logic                              d_rvalid,
  output logic [DATA_W-1:0]                 d_rdata,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic                              stall_i,
  output logic                              stall_d,
  output logic [1:0]                        o_dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]   o_dbg_starve_cnt
);

  // Handshake: a requester holds x_req (and may change addr/data) until done; x_gnt marks the
  // single cycle its access is issued and its fields are sampled; x_rvalid is a one-cycle read-data pulse.
  typedef enum logic [1:0] {IDLE = 2'd0, RD_I = 2'd1, RD_D = 2'd2} state_t;

  localparam int              SW       = $clog2(STARVE_MAX+1);
  localparam logic [3:0]      LAT_C    = 4'(MEM_LAT);
  localparam logic [SW-1:0]   STARVE_C = SW'(STARVE_MAX);

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_lat_cnt, w_lat_nxt;
  logic               r_i_rvalid, r_d_rvalid;
  logic [DATA_W-1:0]  r_i_rdata, r_d_rdata;
  logic               w_i_act, w_d_act, w_pick_i;
  logic               w_gnt_i, w_gnt_d, w_rd_done;

  // A port whose rvalid is pulsing has already been served for the request it is still holding.
  assign w_i_act   = i_req && !r_i_rvalid;
  assign w_d_act   = d_req && !r_d_rvalid;
  assign w_rd_done = (r_state != IDLE) && (r_lat_cnt == 4'd1);

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  assign w_pick_i         = r_last_d;
  assign o_dbg_starve_cnt = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last_d <= 1'b0;
    else if (w_gnt_i) r_last_d <= 1'b0;
    else if (w_gnt_d) r_last_d <= 1'b1;
  end
`else
  logic [SW-1:0] r_starve_cnt;

  assign w_pick_i         = (r_starve_cnt == STARVE_C);
  assign o_dbg_starve_cnt = r_starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_starve_cnt <= '0;
    else if (w_gnt_i)
      r_starve_cnt <= '0;
    else if (w_gnt_d && w_i_act && (r_starve_cnt != STARVE_C))
      r_starve_cnt <= r_starve_cnt + SW'(1);
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    case (r_state)
      IDLE: begin
        // Grants are combinational, so they are held off while reset is asserted.
        if (rst_n) begin
          if (w_i_act && (!w_d_act || w_pick_i)) w_gnt_i = 1'b1;
          else if (w_d_act)                      w_gnt_d = 1'b1;
          if (w_gnt_i) begin
            w_state_nxt = RD_I;
            w_lat_nxt   = LAT_C;
          end else if (w_gnt_d && !d_we) begin
            w_state_nxt = RD_D;
            w_lat_nxt   = LAT_C;
          end
        end
      end
      RD_I, RD_D: begin
        w_lat_nxt = r_lat_cnt - 4'd1;
        if (r_lat_cnt == 4'd1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lat_cnt  <= 4'd0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lat_cnt  <= w_lat_nxt;
      r_i_rvalid <= w_rd_done && (r_state == RD_I);
      r_d_rvalid <= w_rd_done && (r_state == RD_D);
      if (w_rd_done && (r_state == RD_I)) r_i_rdata <= mem_rdata;
      if (w_rd_done && (r_state == RD_D)) r_d_rdata <= mem_rdata;
    end
  end

  assign i_gnt       = w_gnt_i;
  assign d_gnt       = w_gnt_d;
  assign mem_en      = w_gnt_i || w_gnt_d;
  assign mem_we      = w_gnt_d && d_we;
  assign mem_addr    = w_gnt_i ? {2'b00, i_addr[ADDR_W-1:2]} :
                       w_gnt_d ? {2'b00, d_addr[ADDR_W-1:2]} : '0;
  assign mem_wdata   = w_gnt_d ? d_wdata : '0;
  assign i_rvalid    = r_i_rvalid;
  assign d_rvalid    = r_d_rvalid;
  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;
  assign stall_i     = i_req && !r_i_rvalid;
  assign stall_d     = d_req && !(d_we ? w_gnt_d : r_d_rvalid);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with behavioural memories and read-data scoreboards.
// One instance runs with MEM_LAT=1, a second with MEM_LAT=3 for the reset-during-read case.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst_n, x_rst_n;
  int          n_checks = 0;
  int          n_errors = 0;

  // MEM_LAT=1 instance
  logic        i_req, i_gnt, i_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic        mem_en, mem_we, stall_i, stall_d;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_starve;

  // MEM_LAT=3 instance
  logic        x_i_req, x_i_gnt, x_i_rvalid, x_d_req, x_d_we, x_d_gnt, x_d_rvalid;
  logic        x_mem_en, x_mem_we, x_stall_i, x_stall_d;
  logic [31:0] x_i_addr, x_i_rdata, x_d_addr, x_d_wdata, x_d_rdata;
  logic [31:0] x_mem_addr, x_mem_wdata, x_mem_rdata;
  logic [1:0]  x_dbg_state;
  logic [2:0]  x_dbg_starve;

  logic [31:0] i_exp_q[$], d_exp_q[$], x_i_exp_q[$];
  logic [31:0] i_mon_exp, d_mon_exp, x_mon_exp;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_i(stall_i), .stall_d(stall_d),
    .o_dbg_state(dbg_state), .o_dbg_starve_cnt(dbg_starve)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut3 (
    .clk(clk), .rst_n(x_rst_n),
    .i_req(x_i_req), .i_addr(x_i_addr), .i_gnt(x_i_gnt), .i_rvalid(x_i_rvalid), .i_rdata(x_i_rdata),
    .d_req(x_d_req), .d_we(x_d_we), .d_addr(x_d_addr), .d_wdata(x_d_wdata),
    .d_gnt(x_d_gnt), .d_rvalid(x_d_rvalid), .d_rdata(x_d_rdata),
    .mem_en(x_mem_en), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
    .mem_rdata(x_mem_rdata), .stall_i(x_stall_i), .stall_d(x_stall_d),
    .o_dbg_state(x_dbg_state), .o_dbg_starve_cnt(x_dbg_starve)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  logic [31:0] wr_mem [int unsigned];
  logic [31:0] pipe1;
  logic [31:0] x_pipe [0:2];

  function automatic logic [31:0] word1(input logic [31:0] waddr);
    return 32'hA500_0000 + waddr;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) wr_mem[mem_addr] = mem_wdata;
    if (mem_en && !mem_we) pipe1 <= wr_mem.exists(mem_addr) ? wr_mem[mem_addr] : word1(mem_addr);
    else                   pipe1 <= 32'h0;
    x_pipe[0] <= (x_mem_en && !x_mem_we) ? (32'h3300_0000 + x_mem_addr) : 32'h0;
    x_pipe[1] <= x_pipe[0];
    x_pipe[2] <= x_pipe[1];
  end
  assign mem_rdata   = pipe1;
  assign x_mem_rdata = x_pipe[2];

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (rst_n && i_rvalid) begin
      n_checks++;
      assert (i_exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL i_rvalid_spurious: observed pulse, expected none");
      end
      if (i_exp_q.size() != 0) begin
        i_mon_exp = i_exp_q.pop_front();
        n_checks++;
        assert (i_rdata === i_mon_exp) else begin
          n_errors++;
          $error("FAIL i_rdata: observed 0x%0h expected 0x%0h", i_rdata, i_mon_exp);
        end
      end
    end
    if (rst_n && d_rvalid) begin
      n_checks++;
      assert (d_exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL d_rvalid_spurious: observed pulse, expected none");
      end
      if (d_exp_q.size() != 0) begin
        d_mon_exp = d_exp_q.pop_front();
        n_checks++;
        assert (d_rdata === d_mon_exp) else begin
          n_errors++;
          $error("FAIL d_rdata: observed 0x%0h expected 0x%0h", d_rdata, d_mon_exp);
        end
      end
    end
    if (x_rst_n && x_i_rvalid) begin
      n_checks++;
      assert (x_i_exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL x_i_rvalid_spurious: observed pulse, expected none");
      end
      if (x_i_exp_q.size() != 0) begin
        x_mon_exp = x_i_exp_q.pop_front();
        n_checks++;
        assert (x_i_rdata === x_mon_exp) else begin
          n_errors++;
          $error("FAIL x_i_rdata: observed 0x%0h expected 0x%0h", x_i_rdata, x_mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  bit m_last_d;
  int m_starve;

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step();
    step();
    rst_n    = 1'b1;
    m_last_d = 1'b0;
    m_starve = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] st_val0, st_val_win, tmp_w;
  bit          m_i_wins, i_won, exp_d_next, got;
  int          c_win, n_gr, lat;

  initial begin
    rst_n = 1'b0; x_rst_n = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    x_i_req = 0; x_i_addr = 0; x_d_req = 0; x_d_we = 0; x_d_addr = 0; x_d_wdata = 0;
    m_last_d = 0; m_starve = 0; c_win = 0;

    // reset state
    step(); #1;
    chk("rst_i_gnt", i_gnt, 0);        chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);      chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);  chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_rvalid", i_rvalid, 0);  chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_state", dbg_state, 0);    chk("rst_starve", dbg_starve, 0);
    step();
    rst_n = 1'b1; x_rst_n = 1'b1;

    // 1: uncontended fetch, MEM_LAT=1
    step(); i_req = 1; i_addr = 32'h10; i_exp_q.push_back(word1(32'h4)); #1;
    chk("t1_i_gnt", i_gnt, 1);  chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 32'h4); chk("t1_mem_we", mem_we, 0); chk("t1_stall_i", stall_i, 1);
    step(); #1;
    chk("t1_busy_gnt", i_gnt, 0); chk("t1_state_rd_i", dbg_state, 1); chk("t1_busy_en", mem_en, 0);
    step(); #1;
    chk("t1_i_rvalid", i_rvalid, 1); chk("t1_stall_i_done", stall_i, 0); chk("t1_mask", i_gnt, 0);
    step(); i_req = 0; #1;
    chk("t1_rvalid_pulse", i_rvalid, 0); chk("t1_rdata_hold", i_rdata, word1(32'h4));

    // 2: store, one cycle
    step(); d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; #1;
    chk("t2_d_gnt", d_gnt, 1); chk("t2_mem_we", mem_we, 1); chk("t2_mem_addr", mem_addr, 32'h8);
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF); chk("t2_stall_d", stall_d, 0);
    step(); d_req = 0; #1;
    chk("t2_stall_d_next", stall_d, 0); chk("t2_state_idle", dbg_state, 0); chk("t2_mem_wdata_idle", mem_wdata, 0);
    // load back with low address bits set
    step(); d_req = 1; d_we = 0; d_addr = 32'h23; d_exp_q.push_back(32'hDEADBEEF); #1;
    chk("t2_ld_gnt", d_gnt, 1); chk("t2_ld_addr", mem_addr, 32'h8); chk("t2_ld_stall", stall_d, 1);
    step(); #1; chk("t2_state_rd_d", dbg_state, 2);
    step(); #1; chk("t2_d_rvalid", d_rvalid, 1); chk("t2_ld_stall_done", stall_d, 0);
    step(); d_req = 0;

    // 3: simultaneous loads from reset
    do_reset();
    step(); i_req = 1; i_addr = 32'h30; d_req = 1; d_we = 0; d_addr = 32'h40;
    d_exp_q.push_back(word1(32'h10)); i_exp_q.push_back(word1(32'hC)); #1;
    chk("t3_d_first", d_gnt, 1); chk("t3_i_wait", i_gnt, 0); chk("t3_addr", mem_addr, 32'h10);
    step(); #1; chk("t3_state", dbg_state, 2); chk("t3_starve", dbg_starve, RR_MODE ? 0 : 1);
    step(); #1;
    chk("t3_d_rvalid", d_rvalid, 1); chk("t3_i_gnt", i_gnt, 1); chk("t3_d_masked", d_gnt, 0);
    chk("t3_i_addr", mem_addr, 32'hC);
    step(); d_req = 0; #1; chk("t3_state_rd_i", dbg_state, 1); chk("t3_starve_clr", dbg_starve, 0);
    step(); #1; chk("t3_i_rvalid", i_rvalid, 1);
    step(); i_req = 0;

    // 4: back-to-back stores against a waiting fetch
    do_reset();
    i_won = 0;
    for (int c = 0; c < 8 && !i_won; c++) begin
      step();
      i_req = 1; i_addr = 32'h80;
      d_req = 1; d_we = 1; d_addr = 32'h44 + 32'(4 * c); d_wdata = $urandom;
      m_i_wins = RR_MODE ? m_last_d : (m_starve == STARVE_MAX);
      #1;
      chk("t4_i_gnt", i_gnt, m_i_wins);
      chk("t4_d_gnt", d_gnt, !m_i_wins);
      chk("t4_starve", dbg_starve, RR_MODE ? 0 : m_starve);
      if (m_i_wins) begin
        i_won = 1; c_win = c; st_val_win = d_wdata;
        m_starve = 0; m_last_d = 0;
        i_exp_q.push_back(word1(32'h20));
      end else begin
        chk("t4_wdata", mem_wdata, d_wdata);
        if (c == 0) st_val0 = d_wdata;
        if (m_starve < STARVE_MAX) m_starve++;
        m_last_d = 1;
      end
    end
    chk("t4_i_won", i_won, 1);
    chk("t4_win_cycle", c_win, RR_MODE ? 1 : STARVE_MAX);
    step(); #1;
    chk("t4_state_rd_i", dbg_state, 1); chk("t4_starve_zero", dbg_starve, 0);
    chk("t4_d_held", d_gnt, 0); chk("t4_stall_d", stall_d, 1);
    step(); #1;
    chk("t4_i_rvalid", i_rvalid, 1); chk("t4_late_store", d_gnt, 1);
    chk("t4_late_addr", mem_addr, (32'h44 + 32'(4 * c_win)) >> 2);
    chk("t4_late_wdata", mem_wdata, st_val_win);
    step(); i_req = 0; d_req = 0;
    step(); d_req = 1; d_we = 0; d_addr = 32'h44; d_exp_q.push_back(st_val0); #1;
    chk("t4_rb_gnt", d_gnt, 1);
    step(); step(); #1; chk("t4_rb_rvalid", d_rvalid, 1);
    step(); d_req = 0;

    // 5: continuous loads on both ports alternate D, I, D, I
    do_reset();
    n_gr = 0; exp_d_next = 1;
    step(); i_req = 1; i_addr = 32'hC0; d_req = 1; d_we = 0; d_addr = 32'hD0;
    for (int c = 0; c < 24 && n_gr < 4; c++) begin
      #1;
      if (i_gnt || d_gnt) begin
        chk("t5_one_hot", i_gnt & d_gnt, 0);
        chk("t5_order_d", d_gnt, exp_d_next);
        if (d_gnt) d_exp_q.push_back(word1(32'h34));
        else       i_exp_q.push_back(word1(32'h30));
        exp_d_next = !exp_d_next;
        n_gr++;
      end
      step();
    end
    chk("t5_grants", n_gr, 4);
    i_req = 0; d_req = 0;

    // 6: reset during a MEM_LAT=3 read, then a fresh read
    step(); x_i_req = 1; x_i_addr = 32'h24; #1;
    chk("t6_gnt", x_i_gnt, 1); chk("t6_addr", x_mem_addr, 32'h9);
    step(); #1; chk("t6_state_rd_i", x_dbg_state, 1);
    #2; x_rst_n = 0; #1;
    chk("t6_rst_state", x_dbg_state, 0); chk("t6_rst_gnt", x_i_gnt, 0);
    chk("t6_rst_en", x_mem_en, 0); chk("t6_rst_rvalid", x_i_rvalid, 0); chk("t6_rst_rdata", x_i_rdata, 0);
    step(); x_i_req = 0;
    step(); x_rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      step(); #1; chk("t6_no_rvalid", x_i_rvalid, 0);
    end
    step(); x_i_req = 1; x_i_addr = 32'h28; x_i_exp_q.push_back(32'h3300_000A); #1;
    chk("t6_fresh_gnt", x_i_gnt, 1);
    got = 0; lat = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      step(); #1;
      if (x_i_rvalid) begin got = 1; lat = c; end
    end
    chk("t6_latency", lat, 4);
    step(); x_i_req = 0;

    // drain
    for (int c = 0; c < 20 && (i_exp_q.size() + d_exp_q.size() + x_i_exp_q.size()) != 0; c++) step();
    chk("end_i_q_empty", i_exp_q.size(), 0);
    chk("end_d_q_empty", d_exp_q.size(), 0);
    chk("end_x_q_empty", x_i_exp_q.size(), 0);

    tmp_w = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
